// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path.
// Used by the hex digit scanner and by the decoder wrapper downstream.
//   DIGIT_W      : width of one hex digit (decoder SW[3:0] input)
//   BLANK_NIBBLE : digit value that is eligible for leading-zero blanking
//   safe_clog2   : counter width helper that never returns 0
package seg_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BLANK_NIBBLE = '0;

  // $clog2 yields 0 for n <= 1, which would produce zero-width counters.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_digit_scanner_if.sv
// Load/display bundle of the hex digit scanner.
//   load       : single-cycle strobe, captures value into the shadow register
//   value      : DIGITS hex digits, digit i = value[4i+3:4i]
//   nibble     : digit currently scanned, to the decoder
//   digit_en   : one-hot digit select
//   blank      : force decoder output off for this slot
//   pending    : shadow holds a value not yet committed
//   frame_done : one-cycle pulse at each frame wrap
// master = load source / display consumer, slave = scanner.
interface hex_digit_scanner_if #(
  parameter int unsigned DIGITS = 4
);
  import seg_pkg::*;

  logic                        load;
  logic [DIGIT_W*DIGITS-1:0]   value;
  logic [DIGIT_W-1:0]          nibble;
  logic [DIGITS-1:0]           digit_en;
  logic                        blank;
  logic                        pending;
  logic                        frame_done;

  modport master (
    output load, value,
    input  nibble, digit_en, blank, pending, frame_done
  );

  modport slave (
    input  load, value,
    output nibble, digit_en, blank, pending, frame_done
  );

endinterface

// File: rtl/scan_tick_gen.sv
// Scan-rate divider: asserts tick for one cycle every SCAN_DIV clocks.
//   clock : system clock
//   reset : synchronous, active-high; restarts the count at 0
//   tick  : high while div_cnt == SCAN_DIV-1
module scan_tick_gen
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned     CW   = safe_clog2(SCAN_DIV);
  localparam logic [CW-1:0]   LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/hex_digit_scanner.sv
// Time-multiplexes a DIGITS-wide hex value onto one shared 4-bit decoder.
// New values land in a shadow register and are committed to the displayed
// register only at a frame wrap, so one frame never mixes old and new digits.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : load/value in; nibble, digit_en, blank, pending,
//                  frame_done out (all registered, no path from load/value)
module hex_digit_scanner
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned SCAN_DIV      = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  hex_digit_scanner_if.slave  bus
);

  localparam int unsigned   IW       = safe_clog2(DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam int unsigned   VW       = DIGIT_W * DIGITS;

  logic          tick;
  logic          wrap;
  logic [IW-1:0] idx;
  logic [VW-1:0] active;
  logic [VW-1:0] shadow;
  logic          pending;
  logic          frame_done;
  logic          upper_zero;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign wrap = tick && (idx == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) begin
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
      end
      if (wrap && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      // A load coinciding with a commit wins the pending flag: the old shadow
      // is committed and the freshly captured value waits for the next frame.
      if (bus.load) begin
        shadow  <= bus.value;
        pending <= 1'b1;
      end
    end
  end

  // Leading-zero test: the current digit and every higher digit are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ((i >= 32'(idx)) && (active[i*DIGIT_W +: DIGIT_W] != BLANK_NIBBLE)) begin
        upper_zero = 1'b0;
      end
    end
  end

  assign bus.nibble     = active[idx*DIGIT_W +: DIGIT_W];
  assign bus.digit_en   = DIGITS'(1) << idx;
  assign bus.blank      = BLANK_LEADING && (idx != '0) && upper_zero;
  assign bus.pending    = pending;
  assign bus.frame_done = frame_done;

endmodule
